// File: rtl/ofm_pkg.sv
`default_nettype none
// ofm_pkg: shared widths, FSM encoding and read-latency legality rule for the OFM BRAM reader.
// Rev 1.0
package ofm_pkg;

  localparam int RAM_WIDTH        = 64;
  localparam int ADDR_WIDTH       = 4;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 1 = LOW_LATENCY (no output register), 2 = HIGH_PERFORMANCE (output register)
  function automatic bit read_latency_legal(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_rd_fifo.sv
`default_nettype none
// ofm_rd_fifo: small synchronous FIFO holding {last, data} beats with an occupancy count.
// Rev 1.0
module ofm_rd_fifo
  import ofm_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so DEPTH need not be a power of two
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head      = mem[rd_ptr];
  assign occupancy = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ofm_bram_reader.sv
`default_nettype none
// ofm_bram_reader: drains OFM BRAM words 0..count-1 onto a backpressured stream master.
// Optional XOR checksum of streamed words: define OFM_RD_CHECKSUM_EN.  Rev 1.0
module ofm_bram_reader #(
  parameter int RAM_WIDTH    = ofm_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH    = 10,
  parameter int ADDR_WIDTH   = ofm_pkg::ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic                  ram_regce,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [RAM_WIDTH-1:0]  ram_dout,
  output logic [RAM_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [RAM_WIDTH-1:0]  checksum
);

  import ofm_pkg::*;

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  generate
    if (!read_latency_legal(READ_LATENCY) || (FIFO_DEPTH < READ_LATENCY + 2)) begin : g_bad_params
      $error("ofm_bram_reader: illegal READ_LATENCY or FIFO_DEPTH");
    end
  endgenerate

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        n_words;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        count_clamped;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [READ_LATENCY-1:0] last_sr;
  logic [OCC_W-1:0]        occupancy;
  logic [OCC_W:0]          used;
  logic [RAM_WIDTH:0]      head;
  logic                    fifo_empty;
  logic                    accept;
  logic                    issue;
  logic                    issue_last;
  logic                    beat;
  logic                    drained;

  assign count_clamped = (CNT_W'(count) > CNT_W'(RAM_DEPTH)) ? CNT_W'(RAM_DEPTH) : CNT_W'(count);

  // Credit = reads still in the BRAM pipe plus words already buffered; a same-cycle pop is not credited
  always_comb begin
    used = (OCC_W + 1)'(occupancy);
    for (int i = 0; i < READ_LATENCY; i++) begin
      used = used + (OCC_W + 1)'(vld_sr[i]);
    end
  end

  assign accept     = (state == IDLE) && start;
  assign issue      = (state == READ) && (used < (OCC_W + 1)'(FIFO_DEPTH));
  assign issue_last = issue && ((issue_cnt + CNT_W'(1)) == n_words);
  assign beat       = m_tvalid && m_tready;
  assign drained    = (vld_sr == '0) && fifo_empty && (beat_cnt == n_words);

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_en    = 1'b0;
    ram_regce = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DONE : READ;
      end
      READ: begin
        busy      = 1'b1;
        ram_regce = 1'b1;
        ram_en    = issue;
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        ram_regce = 1'b1;
        if (drained) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      n_words   <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      addr      <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      if (accept) begin
        n_words   <= count_clamped;
        issue_cnt <= '0;
        beat_cnt  <= '0;
        addr      <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (!issue_last) addr <= addr + ADDR_WIDTH'(1);
        end
        if (beat) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  ofm_rd_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clka),
    .rst_n     (rsta),
    .push      (vld_sr[READ_LATENCY-1]),
    .push_data ({last_sr[READ_LATENCY-1], ram_dout}),
    .pop       (beat),
    .head      (head),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign ram_we   = 1'b0;
  assign ram_addr = addr;
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = m_tvalid ? head[RAM_WIDTH-1:0] : '0;
  assign m_tlast  = m_tvalid && head[RAM_WIDTH];

`ifdef OFM_RD_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] csum;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta)       csum <= '0;
    else if (accept) csum <= '0;
    else if (beat)   csum <= csum ^ m_tdata;
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofm_bram_reader.sv
`default_nettype none
// tb_ofm_bram_reader: scoreboard bench driving a latency-1 and a latency-2 reader against BRAM models.
// Rev 1.0
module tb_ofm_bram_reader;

  localparam int RW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rsta;
  logic [1:0]           start;
  logic [AW-1:0]        count;
  logic                 tready;
  logic [1:0]           busy, done, ram_en, ram_we, ram_regce, tvalid, tlast;
  logic [1:0][AW-1:0]   ram_addr;
  logic [1:0][RW-1:0]   ram_dout, tdata, checksum;
  logic [RW-1:0]        mem [16];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [RW-1:0] stage1;
    logic [RW-1:0] stage2;

    ofm_bram_reader #(
      .RAM_WIDTH    (RW),
      .RAM_DEPTH    (DEPTH),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (g + 1),
      .FIFO_DEPTH   (4)
    ) u_dut (
      .clka      (clk),
      .rsta      (rsta),
      .start     (start[g]),
      .count     (count),
      .busy      (busy[g]),
      .done      (done[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_regce (ram_regce[g]),
      .ram_addr  (ram_addr[g]),
      .ram_dout  (ram_dout[g]),
      .m_tdata   (tdata[g]),
      .m_tvalid  (tvalid[g]),
      .m_tready  (tready),
      .m_tlast   (tlast[g]),
      .checksum  (checksum[g])
    );

    // BRAM model: array read register, plus output register for the latency-2 instance
    always @(posedge clk) begin
      if (ram_en[g])    stage1 <= mem[ram_addr[g]];
      if (ram_regce[g]) stage2 <= stage1;
    end
    assign ram_dout[g] = (g == 0) ? stage1 : stage2;
  end

  int            vectors;
  int            miscompares;
  int            c;
  int            beats;
  int            done_c;
  int            tv_c;
  int            max_addr;
  bit            held_v;
  logic [64:0]   held;
  logic [64:0]   exp_q [$];
  logic [RW-1:0] csum_exp;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mid-cycle look at instance s; a beat counts if valid and ready are both high before the next edge
  task automatic sample(input int s);
    logic [64:0] bt;
    logic [64:0] e;
    #1;
    bt = {tlast[s], tdata[s]};
    if (held_v && tvalid[s]) check("hold_stable", bt, held);
    held_v = tvalid[s] && !tready;
    held   = bt;
    if (tvalid[s] && tv_c < 0) tv_c = c;
    if (ram_en[s] && int'(ram_addr[s]) > max_addr) max_addr = int'(ram_addr[s]);
    if (done[s] && done_c < 0) done_c = c;
    if (tvalid[s] && tready) begin
      beats++;
      check("beat_expected", 65'(exp_q.size() != 0), 65'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", bt, e);
      end
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
  task automatic xfer(input int s, input int cnt, input int mode,
                      input int exp_first, input int exp_done, input int restart_at);
    int n;
    int b0;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    csum_exp = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), mem[i]});
      csum_exp ^= mem[i];
    end
    b0       = beats;
    done_c   = -1;
    tv_c     = -1;
    max_addr = -1;
    held_v   = 1'b0;
    count    = AW'(cnt);
    tready   = 1'b1;
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    c = 1;
    while (done_c < 0 && c < 300) begin
      tready   = (mode == 0) ? 1'b1 : ((c % 3) == 1);
      start[s] = (c == restart_at);
      if (c == restart_at) count = 4'd3;
      sample(s);
      @(posedge clk);
      #1;
      c++;
    end
    start  = '0;
    tready = 1'b1;
    check("done_seen", 65'(done_c >= 0), 65'd1);
    check("beat_count", 65'(beats - b0), 65'(n));
    check("queue_empty", 65'(exp_q.size()), 65'd0);
    if (exp_done > 0)  check("done_cycle", 65'(done_c), 65'(exp_done));
    if (exp_first > 0) check("first_valid", 65'(tv_c), 65'(exp_first));
    check("max_addr", 65'(max_addr), 65'(n - 1));
`ifdef OFM_RD_CHECKSUM_EN
    check("checksum", 65'(checksum[s]), 65'(csum_exp));
`else
    check("checksum", 65'(checksum[s]), 65'd0);
`endif
    check("idle_after", 65'({busy[s], done[s], tvalid[s], ram_we[s]}), 65'd0);
    exp_q.delete();
  endtask

  initial begin
    int b0;
    vectors     = 0;
    miscompares = 0;
    beats       = 0;
    rsta        = 1'b0;
    start       = '0;
    count       = '0;
    tready      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = (i < DEPTH) ? (64'h11 + 64'(i)) : (64'hDEAD_0000_0000_0000 | 64'(i));
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 65'({busy, done, ram_en, ram_we, ram_regce, tvalid, tlast, ram_addr}), 65'd0);
    check("reset_data", 65'(tdata[0] | tdata[1] | checksum[0] | checksum[1]), 65'd0);
    rsta = 1'b1;
    @(posedge clk);
    #1;

    xfer(0, 10, 0, 3, 14, 0);   // basic drain, latency 1
    xfer(0, 6,  1, 3, -1, 0);   // backpressure
    xfer(1, 4,  0, 4, 9,  0);   // latency 2
    xfer(1, 10, 1, 4, -1, 0);   // latency 2 with backpressure
    xfer(0, 0,  0, -1, 1, 0);   // empty transfer
    xfer(0, 15, 0, 3, 14, 0);   // clamp to RAM depth
    xfer(0, 1,  0, 3, 5,  0);   // single word
    xfer(0, 8,  0, 3, 12, 4);   // second start while busy

    // Asynchronous reset while the third beat is on the bus
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), mem[i]});
    held_v   = 1'b0;
    tv_c     = -1;
    done_c   = -1;
    max_addr = -1;
    b0       = beats;
    count    = AW'(DEPTH);
    tready   = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    c = 1;
    while ((beats - b0) < 2 && c < 50) begin
      sample(0);
      @(posedge clk);
      #1;
      c++;
    end
    check("pre_reset_beats", 65'(beats - b0), 65'd2);
    rsta = 1'b0;
    @(negedge clk);
    check("mid_reset_ctrl", 65'({busy[0], done[0], ram_en[0], ram_we[0], ram_regce[0],
                                 tvalid[0], tlast[0], ram_addr[0]}), 65'd0);
    check("mid_reset_data", 65'(tdata[0] | checksum[0]), 65'd0);
    @(posedge clk);
    #1;
    rsta = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    xfer(0, 10, 0, 3, 14, 0);   // clean drain after reset

    mem[0] = 64'h1;
    mem[1] = 64'h2;
    mem[2] = 64'h4;
    xfer(0, 3, 0, 3, 7, 0);     // checksum words 1,2,4

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
